axi4_lite_arbiter: RTL and testbench

Two-requester arbiter that shares the single `axi4_lite_manager` request port between the instruction-fetch unit (read-only) and the load/store unit (read/write). It locks a grant for the whole bus transaction and registers the granted request so the manager sees stable inputs. It routes completion, data and fault back to the owner only, and adds zero cycles of latency on the uncontended path. It sits between the core front end / LSU and the AXI4-Lite manager.

---
 rtl/axi4_lite_arbiter_pkg.sv | 22 ++
 rtl/axi4_lite_arbiter_grant_sel.sv | 25 ++
 rtl/axi4_lite_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared types for the fetch/LSU arbiter in front of the AXI4-Lite manager.
package axi4_lite_arbiter_pkg;

    localparam int unsigned DEFAULT_AXI_ADDR_WIDTH = 32;
    localparam int unsigned BUS_DATA_WIDTH         = 32;
    localparam int unsigned BUS_STRB_WIDTH         = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN_I,
        ARB_OWN_D
    } arb_owner_t;

    typedef struct packed {
        logic                              rd;
        logic                              wr;
        logic [DEFAULT_AXI_ADDR_WIDTH-1:0] addr;
        logic [BUS_DATA_WIDTH-1:0]         wr_data;
        logic [BUS_STRB_WIDTH-1:0]         wr_strobe;
    } bus_req_t;

endpackage

// File: rtl/axi4_lite_arbiter_grant_sel.sv
// Combinational winner selection; round-robin when ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with data over fetch.
module arb_grant_sel (
    input  logic i_req,
    input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_d,
`endif
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_d = d_req;
        grant_i = i_req & ~d_req;
`ifdef ARB_ROUND_ROBIN_EN
        // On contention the requester that did not own the bus last wins.
        if (i_req && d_req) begin
            grant_d = ~last_d;
            grant_i = last_d;
        end
`endif
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Shares one AXI4-Lite manager port between fetch (read-only) and LSU (read/write).
// Optional round-robin arbitration via `define ARB_ROUND_ROBIN_EN.
module axi4_lite_arbiter
    import axi4_lite_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      i_rd_en,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic [BUS_DATA_WIDTH-1:0] i_rd_data,
    output logic                      i_fault,
    output logic                      i_busy,

    input  logic                      d_rd_en,
    input  logic                      d_wr_en,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [BUS_DATA_WIDTH-1:0] d_wr_data,
    input  logic [BUS_STRB_WIDTH-1:0] d_wr_strobe,
    output logic [BUS_DATA_WIDTH-1:0] d_rd_data,
    output logic                      d_fault,
    output logic                      d_busy,

    output logic                      m_rd_en,
    output logic                      m_wr_en,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [BUS_DATA_WIDTH-1:0] m_wr_data,
    output logic [BUS_STRB_WIDTH-1:0] m_wr_strobe,
    input  logic [BUS_DATA_WIDTH-1:0] m_rd_data,
    input  logic                      m_access_fault,
    input  logic                      m_busy
);

    arb_owner_t owner_q, owner_d;
    bus_req_t   req_q, req_d;
    bus_req_t   i_live, d_live, m_req;
    logic       i_req, d_req, d_en;
    logic       grant_i, grant_d;
    logic       i_sel, d_sel;

    assign d_en  = d_rd_en | d_wr_en;
    // New grants are suppressed while reset is asserted.
    assign i_req = i_rd_en & ~rst;
    assign d_req = d_en & ~rst;

    // Live request payloads; a simultaneous data read+write is issued as a write.
    always_comb begin
        i_live           = '0;
        i_live.rd        = i_rd_en;
        i_live.addr      = DEFAULT_AXI_ADDR_WIDTH'(i_addr);

        d_live           = '0;
        d_live.rd        = d_rd_en & ~d_wr_en;
        d_live.wr        = d_wr_en;
        d_live.addr      = DEFAULT_AXI_ADDR_WIDTH'(d_addr);
        d_live.wr_data   = d_wr_data;
        d_live.wr_strobe = d_wr_strobe;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    arb_grant_sel u_grant_sel (
        .i_req   (i_req),
        .d_req   (d_req),
        .last_d  (last_d_q),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );
`else
    arb_grant_sel u_grant_sel (
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= ARB_IDLE;
            req_q   <= '0;
        end else begin
            owner_q <= owner_d;
            req_q   <= req_d;
        end
    end

    // Next owner, request mux and busy generation.
    always_comb begin
        owner_d = owner_q;
        req_d   = req_q;
        m_req   = '0;
        i_busy  = 1'b0;
        d_busy  = 1'b0;
        i_sel   = 1'b0;
        d_sel   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
`endif
        case (owner_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    m_req  = d_live;
                    d_busy = m_busy;
                    i_busy = i_req;
                    d_sel  = 1'b1;
                    if (m_busy) begin
                        owner_d = ARB_OWN_D;
                        req_d   = d_live;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    else begin
                        last_d_d = 1'b1;
                    end
`endif
                end else if (grant_i) begin
                    m_req  = i_live;
                    i_busy = m_busy;
                    d_busy = d_req;
                    i_sel  = 1'b1;
                    if (m_busy) begin
                        owner_d = ARB_OWN_I;
                        req_d   = i_live;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    else begin
                        last_d_d = 1'b0;
                    end
`endif
                end
            end
            ARB_OWN_I: begin
                m_req  = req_q;
                i_busy = i_rd_en & m_busy;
                d_busy = d_en;
                i_sel  = i_rd_en;
                if (!m_busy) begin
                    owner_d = ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            ARB_OWN_D: begin
                m_req  = req_q;
                d_busy = d_en & m_busy;
                i_busy = i_rd_en;
                d_sel  = d_en;
                if (!m_busy) begin
                    owner_d = ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end
            end
            default: begin
                owner_d = ARB_IDLE;
            end
        endcase
    end

    assign m_rd_en     = m_req.rd;
    assign m_wr_en     = m_req.wr;
    assign m_addr      = ADDR_WIDTH'(m_req.addr);
    assign m_wr_data   = m_req.wr_data;
    assign m_wr_strobe = m_req.wr_strobe;

    // Results reach only a still-requesting owner, in the cycle the manager finishes.
    assign i_rd_data = (i_sel && !m_busy) ? m_rd_data : '0;
    assign d_rd_data = (d_sel && !m_busy) ? m_rd_data : '0;
    assign i_fault   = i_sel & ~m_busy & m_access_fault;
    assign d_fault   = d_sel & ~m_busy & m_access_fault;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed self-checking bench for axi4_lite_arbiter; round-robin ordering is
// exercised only when ARB_ROUND_ROBIN_EN is defined.
module tb_axi4_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd_en;
    logic [31:0] i_addr;
    logic [31:0] i_rd_data;
    logic        i_fault, i_busy;
    logic        d_rd_en, d_wr_en;
    logic [31:0] d_addr, d_wr_data;
    logic [3:0]  d_wr_strobe;
    logic [31:0] d_rd_data;
    logic        d_fault, d_busy;
    logic        m_rd_en, m_wr_en;
    logic [31:0] m_addr, m_wr_data;
    logic [3:0]  m_wr_strobe;
    logic [31:0] m_rd_data;
    logic        m_access_fault, m_busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    axi4_lite_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rd_en        (i_rd_en),
        .i_addr         (i_addr),
        .i_rd_data      (i_rd_data),
        .i_fault        (i_fault),
        .i_busy         (i_busy),
        .d_rd_en        (d_rd_en),
        .d_wr_en        (d_wr_en),
        .d_addr         (d_addr),
        .d_wr_data      (d_wr_data),
        .d_wr_strobe    (d_wr_strobe),
        .d_rd_data      (d_rd_data),
        .d_fault        (d_fault),
        .d_busy         (d_busy),
        .m_rd_en        (m_rd_en),
        .m_wr_en        (m_wr_en),
        .m_addr         (m_addr),
        .m_wr_data      (m_wr_data),
        .m_wr_strobe    (m_wr_strobe),
        .m_rd_data      (m_rd_data),
        .m_access_fault (m_access_fault),
        .m_busy         (m_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, well clear of the next rising edge.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; i_rd_en = 0; i_addr = 0;
        d_rd_en = 0; d_wr_en = 0; d_addr = 0; d_wr_data = 0; d_wr_strobe = 0;
        m_rd_data = 0; m_access_fault = 0; m_busy = 0;
        cyc(); cyc();
        settle();
        check("rst_m_rd_en", 32'(m_rd_en), 0);
        check("rst_m_wr_en", 32'(m_wr_en), 0);
        check("rst_busy", {30'd0, i_busy, d_busy}, 0);
        check("rst_fault", {30'd0, i_fault, d_fault}, 0);
        rst = 1'b0;

        // Fetch alone: three busy cycles then completion with data.
        cyc();
        i_rd_en = 1; i_addr = 32'h100; m_busy = 1;
        settle();
        check("fetch_addr_c0", m_addr, 32'h100);
        check("fetch_rd_en_c0", 32'(m_rd_en), 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                cyc();
                m_busy = (k < 3);
                m_rd_data = (k == 3) ? 32'hDEADBEEF : 32'h0;
                settle();
            end
            check($sformatf("fetch_i_busy_c%0d", k), 32'(i_busy), (k < 3) ? 1 : 0);
            check($sformatf("fetch_d_busy_c%0d", k), 32'(d_busy), 0);
        end
        check("fetch_m_addr_held", m_addr, 32'h100);
        check("fetch_rd_data", i_rd_data, 32'hDEADBEEF);
        check("fetch_fault", 32'(i_fault), 0);
        cyc();
        i_rd_en = 0; m_busy = 0; m_rd_data = 0;

        // Contention: data write wins, owner address change is ignored.
        cyc();
        i_rd_en = 1; i_addr = 32'h200;
        d_wr_en = 1; d_addr = 32'h300; d_wr_data = 32'h12345678; d_wr_strobe = 4'hF;
        m_busy = 1;
        settle();
        check("sim_m_addr", m_addr, 32'h300);
        check("sim_m_wr_en", 32'(m_wr_en), 1);
        check("sim_m_rd_en", 32'(m_rd_en), 0);
        check("sim_strobe", 32'(m_wr_strobe), 32'hF);
        check("sim_wdata", m_wr_data, 32'h12345678);
        check("sim_i_busy", 32'(i_busy), 1);
        cyc();
        d_addr = 32'h400;
        settle();
        check("stable_m_addr", m_addr, 32'h300);
        check("stable_i_busy", 32'(i_busy), 1);
        cyc();
        m_busy = 0;
        settle();
        check("sim_d_done", 32'(d_busy), 0);
        check("sim_i_still_busy", 32'(i_busy), 1);
        check("stable_m_addr_done", m_addr, 32'h300);
        cyc();
        d_wr_en = 0; m_busy = 1;
        settle();
        check("sim_fetch_addr", m_addr, 32'h200);
        check("sim_fetch_rd_en", 32'(m_rd_en), 1);
        cyc();
        m_busy = 0; m_rd_data = 32'hCAFEF00D;
        settle();
        check("sim_fetch_data", i_rd_data, 32'hCAFEF00D);
        check("sim_fetch_busy", 32'(i_busy), 0);
        check("sim_d_rd_data_zero", d_rd_data, 0);
        cyc();
        i_rd_en = 0; m_rd_data = 0;

        // Fault on a data read: one cycle only, never leaks to fetch.
        cyc();
        d_rd_en = 1; d_addr = 32'hF000_0000; m_busy = 1;
        cyc();
        m_busy = 0; m_access_fault = 1;
        settle();
        check("fault_d_fault", 32'(d_fault), 1);
        check("fault_d_busy", 32'(d_busy), 0);
        check("fault_i_fault", 32'(i_fault), 0);
        cyc();
        d_rd_en = 0;
        settle();
        check("fault_one_cycle", 32'(d_fault), 0);
        m_access_fault = 0;

        // Read and write together: issued as a write, immediate completion.
        cyc();
        d_rd_en = 1; d_wr_en = 1; d_addr = 32'h340; m_busy = 0;
        settle();
        check("rw_m_wr_en", 32'(m_wr_en), 1);
        check("rw_m_rd_en", 32'(m_rd_en), 0);
        check("rw_d_busy", 32'(d_busy), 0);
        cyc();
        d_rd_en = 0; d_wr_en = 0;

        // Owner drops its enable mid-transaction: bus keeps the latched request.
        cyc();
        d_rd_en = 1; d_addr = 32'h700; m_busy = 1;
        cyc();
        d_rd_en = 0;
        settle();
        check("drop_d_busy", 32'(d_busy), 0);
        check("drop_m_rd_en", 32'(m_rd_en), 1);
        check("drop_m_addr", m_addr, 32'h700);
        cyc();
        m_busy = 0; m_access_fault = 1;
        settle();
        check("drop_fault_discard", 32'(d_fault), 0);
        cyc();
        m_access_fault = 0; i_rd_en = 1; i_addr = 32'h800; m_busy = 1;
        settle();
        check("drop_next_grant", m_addr, 32'h800);
        cyc();
        m_busy = 0; m_rd_data = 32'h0000_0800;
        settle();
        check("drop_next_data", i_rd_data, 32'h0000_0800);
        cyc();
        i_rd_en = 0; m_rd_data = 0;

`ifdef ARB_ROUND_ROBIN_EN
        // Both held continuously: owners alternate D, I, D, I.
        cyc();
        i_rd_en = 1; i_addr = 32'h200; d_rd_en = 1; d_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            m_busy = 1;
            settle();
            check($sformatf("rr_owner_%0d", k), m_addr, (k % 2 == 0) ? 32'h300 : 32'h200);
            cyc();
            m_busy = 0;
        end
        cyc();
        i_rd_en = 0; d_rd_en = 0;
`endif

        // Reset while fetch owns the bus.
        cyc();
        i_rd_en = 1; i_addr = 32'h500; m_busy = 1;
        cyc();
        rst = 1;
        settle();
        check("rstmid_m_rd_en_before", 32'(m_rd_en), 1);
        check("rstmid_m_addr_before", m_addr, 32'h500);
        cyc();
        m_busy = 0;
        settle();
        check("rstmid_m_rd_en", 32'(m_rd_en), 0);
        check("rstmid_i_busy", 32'(i_busy), 0);
        cyc();
        rst = 0; i_rd_en = 0; d_rd_en = 1; d_addr = 32'h600; m_busy = 1;
        settle();
        check("rstmid_d_grant", m_addr, 32'h600);
        check("rstmid_d_busy", 32'(d_busy), 1);
        cyc();
        m_busy = 0; m_rd_data = 32'h0000_55AA;
        settle();
        check("rstmid_d_data", d_rd_data, 32'h0000_55AA);
        check("rstmid_d_done", 32'(d_busy), 0);
        cyc();
        d_rd_en = 0; m_rd_data = 0;

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
